alarm_annunciator: RTL and testbench
====================================

ALARM_ANNUNCIATOR -- requirements
Module: alarm_annunciator

Interface
REQ-001 SHALL provide parameter BLINK_HALF, default 5, slow-blink half-period in iCLK cycles (500 ms at the 100 ms clock).
REQ-002 SHALL provide parameter FAST_HALF, default 2, fast-blink half-period in iCLK cycles.
REQ-003 SHALL provide parameter SIREN_ON, default 3, siren-on cycles per pulse in ALARM mode.
REQ-004 SHALL provide parameter SIREN_OFF, default 2, siren-off cycles per pulse in ALARM mode.
REQ-005 SHALL have port iCLK, input, 1, system clock with 100 ms period, rising-edge active.
REQ-006 SHALL have port iRST, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port state, input, 5, alarm controller state code.
REQ-008 SHALL have port mode, output, 3, annunciation mode: 0 IDLE, 1 PEND, 2 ARMED, 3 ALARM, 4 PANIC.
REQ-009 SHALL have ports armed_led, pending_led, panic_led, siren, state_err, output, 1 each.
REQ-010 SHALL have port zone_led, output, 3, per-zone indicator; bit n is zone n+1.

Function
REQ-011 SHALL decode state codes: 0x0 RESET, 0x1 DISARMED, 0x2 ARMED_PENDING, 0x3 ARMED, 0x4 TRIGGERED, 0x5 TRIGGERED_RESET, 0x6/0x7/0x8 CHECK_ZONE_1/2/3, 0x9/0xA/0xB ZONE_1/2/3_ON, 0xC/0xD/0xE ZONE_1/2/3_OFF, 0xF DELAY, 0x10 PANIC, 0x11 PANIC_RESET, 0x12 UPDATE; 0x13-0x1F invalid.
REQ-012 SHALL sample state on every rising iCLK edge; all outputs are registered and reflect the code sampled at that edge (one-cycle latency, no combinational path from state).
REQ-013 SHALL hold an internal mode register: RESET/DISARMED -> IDLE; ARMED_PENDING -> PEND; ARMED -> ARMED; TRIGGERED/TRIGGERED_RESET -> ALARM; PANIC/PANIC_RESET -> PANIC; CHECK_ZONE_x, ZONE_x_ON/OFF, DELAY, UPDATE -> mode unchanged; mode output equals this register.
REQ-014 SHALL set zone_led bit n on ZONE_n+1_ON and clear it on ZONE_n+1_OFF; other bits unchanged; code RESET clears all three bits.
REQ-015 SHALL run a blink counter 0..2*BLINK_HALF-1 and a fast counter 0..2*FAST_HALF-1, wrapping to 0; phase is ON while count < HALF.
REQ-016 SHALL run a siren counter 0..SIREN_ON+SIREN_OFF-1, wrapping to 0; siren phase ON while count < SIREN_ON.
REQ-017 SHALL restart all three counters at 0 (ON phase) on the edge where the mode register changes value; first output cycle of a new mode is an ON phase.
REQ-018 SHALL drive pending_led = fast phase in PEND, else 0.
REQ-019 SHALL drive armed_led = 1 in ARMED and ALARM, else 0.
REQ-020 SHALL drive panic_led = 1 and siren = 1 continuously in PANIC.
REQ-021 SHALL drive siren = siren phase in ALARM, 0 in IDLE, PEND, ARMED.
REQ-022 SHALL present zone_led as latched bits ANDed with slow phase in ALARM, latched bits steady in all other modes.
REQ-023 SHALL on an invalid code drive state_err = 1 for that sample, freeze mode, zone latches, counters and all other outputs at previous values; state_err = 0 on any valid code.
REQ-024 SHALL treat a mode change and a zone update in the same sample as independent; both take effect on that edge.

Reset
REQ-025 SHALL on iRST assertion immediately force mode = 0, zone_led = 0, all single-bit outputs 0, all counters 0, independent of iCLK.
REQ-026 SHALL resume sampling on the first rising iCLK edge after iRST deasserts; reset mid-siren or mid-blink discards phase.

Verification
REQ-027 Reset: iRST = 1 during PANIC with siren = 1 -> siren, panic_led, mode, zone_led all 0 before next edge.
REQ-028 Zone latch: drive 0x6,0x9,0x7,0xD,0x8,0xB -> zone_led = 3'b101 one cycle after 0xB sampled, mode stays 0.
REQ-029 Pending: hold 0x2 for 8 cycles from IDLE -> pending_led 1,1,0,0,1,1,0,0; mode = 1; armed_led = 0.
REQ-030 Alarm: zone latch 3'b101, hold 0x4 for 10 cycles -> siren 1,1,1,0,0,1,1,1,0,0; zone_led 101 x5 then 000 x5; armed_led = 1; mode = 3.
REQ-031 Panic exit: 0x10, 0x11 x4, then 0x1 -> siren and panic_led 1 for 5 cycles, 0 on cycle after 0x1 sampled; mode 4 -> 0.
REQ-032 Invalid: in ALARM drive 0x15 for 3 cycles then 0x4 -> state_err = 1 for 3 cycles, siren/zone_led frozen, counters resume from frozen value without restart.

Source files
------------

// File: rtl/alarm_annunciator.sv
// Alarm panel annunciator: decodes the controller state code into registered
// LED/siren drive with slow/fast blink and pulsed siren cadences.
module alarm_annunciator #(
    parameter int BLINK_HALF = 5,
    parameter int FAST_HALF  = 2,
    parameter int SIREN_ON   = 3,
    parameter int SIREN_OFF  = 2
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [4:0] state,
    output logic [2:0] mode,
    output logic       armed_led,
    output logic       pending_led,
    output logic       panic_led,
    output logic       siren,
    output logic       state_err,
    output logic [2:0] zone_led
);

    typedef enum logic [2:0] {
        M_IDLE  = 3'd0,
        M_PEND  = 3'd1,
        M_ARMED = 3'd2,
        M_ALARM = 3'd3,
        M_PANIC = 3'd4
    } mode_t;

    localparam int BW = $clog2(2 * BLINK_HALF) > 0 ? $clog2(2 * BLINK_HALF) : 1;
    localparam int FW = $clog2(2 * FAST_HALF) > 0 ? $clog2(2 * FAST_HALF) : 1;
    localparam int SW = $clog2(SIREN_ON + SIREN_OFF) > 0 ? $clog2(SIREN_ON + SIREN_OFF) : 1;
    localparam logic [BW-1:0] B_LAST = BW'(2 * BLINK_HALF - 1);
    localparam logic [FW-1:0] F_LAST = FW'(2 * FAST_HALF - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SIREN_ON + SIREN_OFF - 1);

    mode_t         mode_q, mode_d;
    logic [2:0]    zone_q, zone_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [FW-1:0] fast_q, fast_d;
    logic [SW-1:0] siren_q, siren_d;
    logic          valid, restart;
    logic          blink_on, fast_on, siren_on;
    logic          armed_d, pending_d, panic_d, siren_out_d;
    logic [2:0]    zone_led_d;

    always_comb begin
        mode_d = mode_q;
        zone_d = zone_q;
        valid  = (state <= 5'h12);
        case (state)
            5'h00:        begin mode_d = M_IDLE; zone_d = 3'b000; end
            5'h01:        mode_d = M_IDLE;
            5'h02:        mode_d = M_PEND;
            5'h03:        mode_d = M_ARMED;
            5'h04, 5'h05: mode_d = M_ALARM;
            5'h10, 5'h11: mode_d = M_PANIC;
            5'h09:        zone_d[0] = 1'b1;
            5'h0A:        zone_d[1] = 1'b1;
            5'h0B:        zone_d[2] = 1'b1;
            5'h0C:        zone_d[0] = 1'b0;
            5'h0D:        zone_d[1] = 1'b0;
            5'h0E:        zone_d[2] = 1'b0;
            default:      ;
        endcase

        // Entering a new mode always starts every cadence at the top of its ON phase.
        restart = (mode_d != mode_q);
        blink_d = (restart || blink_q == B_LAST) ? '0 : blink_q + 1'b1;
        fast_d  = (restart || fast_q  == F_LAST) ? '0 : fast_q + 1'b1;
        siren_d = (restart || siren_q == S_LAST) ? '0 : siren_q + 1'b1;

        blink_on = (int'(blink_d) < BLINK_HALF);
        fast_on  = (int'(fast_d) < FAST_HALF);
        siren_on = (int'(siren_d) < SIREN_ON);

        pending_d   = (mode_d == M_PEND) && fast_on;
        armed_d     = (mode_d == M_ARMED) || (mode_d == M_ALARM);
        panic_d     = (mode_d == M_PANIC);
        siren_out_d = (mode_d == M_PANIC) || ((mode_d == M_ALARM) && siren_on);
        zone_led_d  = ((mode_d == M_ALARM) && !blink_on) ? 3'b000 : zone_d;
    end

    // Invalid codes only raise state_err; everything else holds its value.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            mode_q      <= M_IDLE;
            zone_q      <= '0;
            blink_q     <= '0;
            fast_q      <= '0;
            siren_q     <= '0;
            armed_led   <= 1'b0;
            pending_led <= 1'b0;
            panic_led   <= 1'b0;
            siren       <= 1'b0;
            state_err   <= 1'b0;
            zone_led    <= '0;
        end else if (valid) begin
            mode_q      <= mode_d;
            zone_q      <= zone_d;
            blink_q     <= blink_d;
            fast_q      <= fast_d;
            siren_q     <= siren_d;
            armed_led   <= armed_d;
            pending_led <= pending_d;
            panic_led   <= panic_d;
            siren       <= siren_out_d;
            state_err   <= 1'b0;
            zone_led    <= zone_led_d;
        end else begin
            state_err   <= 1'b1;
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_alarm_annunciator.sv
// Bench for alarm_annunciator: directed scenarios plus random codes against an
// elapsed-time reference model (cadence phases derived by modulo arithmetic).
module tb_alarm_annunciator;

    localparam int BH = 5, FH = 2, SON = 3, SOFF = 2;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic [4:0] state = 5'h00;
    logic [2:0] mode, zone_led;
    logic       armed_led, pending_led, panic_led, siren, state_err;

    int total = 0, passed = 0;

    int         m_mode, m_t;
    logic [2:0] m_zone;
    logic       m_err;

    alarm_annunciator #(.BLINK_HALF(BH), .FAST_HALF(FH), .SIREN_ON(SON), .SIREN_OFF(SOFF)) dut (
        .iCLK(iCLK), .iRST(iRST), .state(state), .mode(mode),
        .armed_led(armed_led), .pending_led(pending_led), .panic_led(panic_led),
        .siren(siren), .state_err(state_err), .zone_led(zone_led)
    );

    always #5 iCLK = ~iCLK;

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_zone = 3'b000; m_err = 1'b0;
    endtask

    // m_t counts samples spent in the current mode; each cadence is m_t modulo its period.
    task automatic model(input logic [4:0] s);
        int nm;
        int c;
        c = int'(s);
        if (c > 18) begin
            m_err = 1'b1;
            return;
        end
        m_err = 1'b0;
        nm = m_mode;
        if (c <= 1) nm = 0;
        else if (c == 2) nm = 1;
        else if (c == 3) nm = 2;
        else if (c == 4 || c == 5) nm = 3;
        else if (c == 16 || c == 17) nm = 4;
        if (c == 0) m_zone = 3'b000;
        else if (c >= 9 && c <= 11) m_zone[c-9] = 1'b1;
        else if (c >= 12 && c <= 14) m_zone[c-12] = 1'b0;
        m_t = (nm != m_mode) ? 0 : m_t + 1;
        m_mode = nm;
    endtask

    function automatic logic [10:0] expv();
        logic       pend, arm, pan, sir;
        logic [2:0] z;
        pend = (m_mode == 1) && ((m_t % (2 * FH)) < FH);
        arm  = (m_mode == 2) || (m_mode == 3);
        pan  = (m_mode == 4);
        sir  = (m_mode == 4) || ((m_mode == 3) && ((m_t % (SON + SOFF)) < SON));
        z    = ((m_mode == 3) && ((m_t % (2 * BH)) >= BH)) ? 3'b000 : m_zone;
        return {m_mode[2:0], z, arm, pend, pan, sir, m_err};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk(tag, {5'b0, mode, zone_led, armed_led, pending_led, panic_led, siren, state_err},
            {5'b0, expv()});
    endtask

    task automatic step(input logic [4:0] s);
        state = s;
        @(posedge iCLK);
        model(s);
        #1;
        check_all("step");
    endtask

    // Reset lands mid-cycle; outputs must clear before the next clock edge.
    task automatic async_reset();
        #2 iRST = 1'b1;
        #1 model_reset();
        check_all("async_rst");
        @(negedge iCLK);
        iRST = 1'b0;
    endtask

    initial begin
        logic [7:0] pat8;
        logic [9:0] sir10, zon10;
        logic [4:0] pan5;
        logic [4:0] codes [6];

        model_reset();
        #1 check_all("reset_hold");
        @(negedge iCLK);
        @(negedge iCLK);
        iRST = 1'b0;

        // Zone latch while idle
        codes = '{5'h06, 5'h09, 5'h07, 5'h0D, 5'h08, 5'h0B};
        foreach (codes[i]) step(codes[i]);
        chk("zone_latch", {13'b0, zone_led}, 16'h0005);
        chk("zone_mode", {13'b0, mode}, 16'h0000);

        // Pending fast blink
        step(5'h01);
        pat8 = '0;
        for (int i = 0; i < 8; i++) begin
            step(5'h02);
            pat8 = {pat8[6:0], pending_led};
        end
        chk("pend_pat", {8'b0, pat8}, 16'h00CC);
        chk("pend_mode", {13'b0, mode}, 16'h0001);

        // Alarm siren and zone blink
        sir10 = '0; zon10 = '0;
        for (int i = 0; i < 10; i++) begin
            step(5'h04);
            sir10 = {sir10[8:0], siren};
            zon10 = {zon10[8:0], (zone_led == 3'b101)};
        end
        chk("alarm_siren", {6'b0, sir10}, {6'b0, 10'b1110011100});
        chk("alarm_zone", {6'b0, zon10}, {6'b0, 10'b1111100000});
        chk("alarm_armed", {15'b0, armed_led}, 16'h0001);

        // Invalid codes freeze mid-cadence, then counting resumes
        for (int i = 0; i < 3; i++) step(5'h04);
        for (int i = 0; i < 3; i++) begin
            step(5'h15);
            chk("inv_err", {15'b0, state_err}, 16'h0001);
        end
        step(5'h04);
        chk("inv_resume_siren", {15'b0, siren}, 16'h0000);
        chk("inv_resume_err", {15'b0, state_err}, 16'h0000);

        // Panic and exit
        pan5 = '0;
        step(5'h10);
        pan5 = {pan5[3:0], siren & panic_led};
        for (int i = 0; i < 4; i++) begin
            step(5'h11);
            pan5 = {pan5[3:0], siren & panic_led};
        end
        chk("panic_on", {11'b0, pan5}, 16'h001F);
        step(5'h01);
        chk("panic_exit", {13'b0, mode, siren, panic_led}, 16'h0000);

        // Reset in the middle of panic
        step(5'h10);
        step(5'h11);
        async_reset();
        chk("rst_panic", {11'b0, mode, siren, panic_led}, 16'h0000);

        // Random codes, biased toward valid ones, with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) step(5'($urandom_range(19, 31)));
            else step(5'($urandom_range(0, 18)));
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
